// File: rtl/hazard_fwd_unit_if.sv
// Bundle between the 5-stage RV32 datapath and the hazard/forwarding unit.
// Signals:
//   ID-stage instruction fields : id_valid, id_rs1/2, id_use_rs1/2, id_rd,
//                                 id_regwrite, id_memread, id_memwrite
//   EX/MEM status               : ex_redirect, dmem_ready
//   pipeline control            : stall_if, stall_id, flush_id, flush_ex, freeze
//   EX operand selects          : fwd_a, fwd_b (00 regfile, 01 EX/MEM, 10 WB)
//   performance counters        : cnt_stall, cnt_flush, cnt_freeze
// master = datapath side, slave = hazard_fwd_unit.
interface hazard_fwd_unit_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_memread;
  logic              id_memwrite;
  logic              ex_redirect;
  logic              dmem_ready;

  logic              stall_if;
  logic              stall_id;
  logic              flush_id;
  logic              flush_ex;
  logic              freeze;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [CNT_W-1:0]  cnt_stall;
  logic [CNT_W-1:0]  cnt_flush;
  logic [CNT_W-1:0]  cnt_freeze;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_memread, id_memwrite, ex_redirect, dmem_ready,
    input  stall_if, stall_id, flush_id, flush_ex, freeze, fwd_a, fwd_b,
           cnt_stall, cnt_flush, cnt_freeze
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_memread, id_memwrite, ex_redirect, dmem_ready,
    output stall_if, stall_id, flush_id, flush_ex, freeze, fwd_a, fwd_b,
           cnt_stall, cnt_flush, cnt_freeze
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding for the 5-stage RV32 pipeline.
// Keeps shadow copies of the EX/MEM/WB stage contents and derives:
//   freeze            - MEM data access waiting on dmem_ready; holds everything
//   load-use stall    - one-cycle stall + EX bubble when ID needs a load result
//   redirect flush    - taken branch/jump in EX kills ID and EX inputs
//   fwd_a/fwd_b       - EX operand source (MEM has priority over WB)
// Ports: clk, reset (async, active-low), bus (hazard_fwd_unit_if.slave).
// Macro PERF_CNT_EN adds saturating stall/flush/freeze counters; without it the
// counter outputs are tied to zero.
module hazard_fwd_unit #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  hazard_fwd_unit_if.slave   bus
);

  // EX shadow
  logic              ex_valid_q, ex_valid_d;
  logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d;
  logic [REG_AW-1:0] ex_rs2_q, ex_rs2_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic              ex_rw_q, ex_rw_d;
  logic              ex_mr_q, ex_mr_d;
  logic              ex_mw_q, ex_mw_d;
  // MEM shadow
  logic              mem_valid_q, mem_valid_d;
  logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
  logic              mem_rw_q, mem_rw_d;
  logic              mem_mr_q, mem_mr_d;
  logic              mem_mw_q, mem_mw_d;
  // WB shadow
  logic              wb_valid_q, wb_valid_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
  logic              wb_rw_q, wb_rw_d;
  logic              wb_mr_q, wb_mr_d;
  logic              wb_mw_q, wb_mw_d;

  logic       freeze_c;
  logic       load_use_c;
  logic       redirect_c;
  logic       stall_c;
  logic       flush_id_c;
  logic       flush_ex_c;
  logic       do_stall_c;
  logic       do_flush_c;
  logic [1:0] fwd_a_c;
  logic [1:0] fwd_b_c;

  // WB memory-access bits are tracked for completeness but drive nothing.
  logic unused_wb_c;
  assign unused_wb_c = wb_mr_q ^ wb_mw_q;

  // Hazard conditions
  always_comb begin
    freeze_c   = mem_valid_q & (mem_mr_q | mem_mw_q) & ~bus.dmem_ready;
    load_use_c = ex_valid_q & ex_mr_q & (ex_rd_q != '0) & bus.id_valid &
                 ((bus.id_use_rs1 & (bus.id_rs1 == ex_rd_q)) |
                  (bus.id_use_rs2 & (bus.id_rs2 == ex_rd_q)));
    redirect_c = ex_valid_q & bus.ex_redirect;
  end

  // Control priority: freeze, then redirect (ID is wrong-path), then load-use
  always_comb begin
    stall_c    = 1'b0;
    flush_id_c = 1'b0;
    flush_ex_c = 1'b0;
    do_stall_c = 1'b0;
    do_flush_c = 1'b0;
    if (freeze_c) begin
      stall_c = 1'b1;
    end else if (redirect_c) begin
      flush_id_c = 1'b1;
      flush_ex_c = 1'b1;
      do_flush_c = 1'b1;
    end else if (load_use_c) begin
      stall_c    = 1'b1;
      flush_ex_c = 1'b1;
      do_stall_c = 1'b1;
    end
  end

  // Operand select for one EX source; MEM result is newer than WB
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (mem_valid_q && mem_rw_q && (mem_rd_q != '0) && (mem_rd_q == rs))
      sel = 2'b01;
    else if (wb_valid_q && wb_rw_q && (wb_rd_q != '0) && (wb_rd_q == rs))
      sel = 2'b10;
    return sel;
  endfunction

  always_comb begin
    fwd_a_c = fwd_sel(ex_rs1_q);
    fwd_b_c = fwd_sel(ex_rs2_q);
  end

  // Shadow next-state: hold everything while frozen, else advance one stage
  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_rs1_d    = ex_rs1_q;
    ex_rs2_d    = ex_rs2_q;
    ex_rd_d     = ex_rd_q;
    ex_rw_d     = ex_rw_q;
    ex_mr_d     = ex_mr_q;
    ex_mw_d     = ex_mw_q;
    mem_valid_d = mem_valid_q;
    mem_rd_d    = mem_rd_q;
    mem_rw_d    = mem_rw_q;
    mem_mr_d    = mem_mr_q;
    mem_mw_d    = mem_mw_q;
    wb_valid_d  = wb_valid_q;
    wb_rd_d     = wb_rd_q;
    wb_rw_d     = wb_rw_q;
    wb_mr_d     = wb_mr_q;
    wb_mw_d     = wb_mw_q;
    if (!freeze_c) begin
      ex_valid_d  = bus.id_valid & ~flush_ex_c;
      ex_rs1_d    = bus.id_rs1;
      ex_rs2_d    = bus.id_rs2;
      ex_rd_d     = bus.id_rd;
      ex_rw_d     = bus.id_regwrite;
      ex_mr_d     = bus.id_memread;
      ex_mw_d     = bus.id_memwrite;
      mem_valid_d = ex_valid_q;
      mem_rd_d    = ex_rd_q;
      mem_rw_d    = ex_rw_q;
      mem_mr_d    = ex_mr_q;
      mem_mw_d    = ex_mw_q;
      wb_valid_d  = mem_valid_q;
      wb_rd_d     = mem_rd_q;
      wb_rw_d     = mem_rw_q;
      wb_mr_d     = mem_mr_q;
      wb_mw_d     = mem_mw_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_q  <= 1'b0;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
      ex_rd_q     <= '0;
      ex_rw_q     <= 1'b0;
      ex_mr_q     <= 1'b0;
      ex_mw_q     <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_rd_q    <= '0;
      mem_rw_q    <= 1'b0;
      mem_mr_q    <= 1'b0;
      mem_mw_q    <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_rw_q     <= 1'b0;
      wb_mr_q     <= 1'b0;
      wb_mw_q     <= 1'b0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_rs1_q    <= ex_rs1_d;
      ex_rs2_q    <= ex_rs2_d;
      ex_rd_q     <= ex_rd_d;
      ex_rw_q     <= ex_rw_d;
      ex_mr_q     <= ex_mr_d;
      ex_mw_q     <= ex_mw_d;
      mem_valid_q <= mem_valid_d;
      mem_rd_q    <= mem_rd_d;
      mem_rw_q    <= mem_rw_d;
      mem_mr_q    <= mem_mr_d;
      mem_mw_q    <= mem_mw_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_rw_q     <= wb_rw_d;
      wb_mr_q     <= wb_mr_d;
      wb_mw_q     <= wb_mw_d;
    end
  end

  assign bus.stall_if = stall_c;
  assign bus.stall_id = stall_c;
  assign bus.flush_id = flush_id_c;
  assign bus.flush_ex = flush_ex_c;
  assign bus.freeze   = freeze_c;
  assign bus.fwd_a    = fwd_a_c;
  assign bus.fwd_b    = fwd_b_c;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cnt_stall_q, cnt_stall_d;
  logic [CNT_W-1:0] cnt_flush_q, cnt_flush_d;
  logic [CNT_W-1:0] cnt_freeze_q, cnt_freeze_d;

  // Saturating event counters
  always_comb begin
    cnt_stall_d  = cnt_stall_q;
    cnt_flush_d  = cnt_flush_q;
    cnt_freeze_d = cnt_freeze_q;
    if (do_stall_c && (cnt_stall_q != '1))
      cnt_stall_d = cnt_stall_q + CNT_W'(1);
    if (do_flush_c && (cnt_flush_q != '1))
      cnt_flush_d = cnt_flush_q + CNT_W'(1);
    if (freeze_c && (cnt_freeze_q != '1))
      cnt_freeze_d = cnt_freeze_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_stall_q  <= '0;
      cnt_flush_q  <= '0;
      cnt_freeze_q <= '0;
    end else begin
      cnt_stall_q  <= cnt_stall_d;
      cnt_flush_q  <= cnt_flush_d;
      cnt_freeze_q <= cnt_freeze_d;
    end
  end

  assign bus.cnt_stall  = cnt_stall_q;
  assign bus.cnt_flush  = cnt_flush_q;
  assign bus.cnt_freeze = cnt_freeze_q;
`else
  logic unused_evt_c;
  assign unused_evt_c   = do_stall_c ^ do_flush_c;
  assign bus.cnt_stall  = {CNT_W{1'b0}};
  assign bus.cnt_flush  = {CNT_W{1'b0}};
  assign bus.cnt_freeze = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: a cycle-by-cycle vector table of
// ID-stage inputs with hand-derived control/forwarding expectations, plus
// hand-written reset and counter sequences.
module tb_hazard_fwd_unit;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 32;

  logic clk;
  logic reset;

  hazard_fwd_unit_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  hazard_fwd_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp layout: {stall_if, stall_id, flush_id, flush_ex, freeze, fwd_a, fwd_b}
  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       mw;
    logic       redir;
    logic       rdy;
    logic [8:0] exp;
    logic       dc;   // fwd selects are don't-care (EX holds a bubble)
  } vec_t;

  typedef struct {
    int         idx;
    logic [8:0] exp;
    logic       dc;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(
    input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic u1, input logic u2, input logic [4:0] rd,
    input logic rw, input logic mr, input logic mw,
    input logic redir, input logic rdy,
    input logic st, input logic fid, input logic fex, input logic frz,
    input logic [1:0] fa, input logic [1:0] fb, input logic dc);
    vec_t t;
    t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.u1 = u1; t.u2 = u2; t.rd = rd;
    t.rw = rw; t.mr = mr; t.mw = mw; t.redir = redir; t.rdy = rdy;
    t.exp = {st, st, fid, fex, frz, fa, fb};
    t.dc = dc;
    return t;
  endfunction

  function automatic logic [8:0] outs();
    return {bus.stall_if, bus.stall_id, bus.flush_id, bus.flush_ex,
            bus.freeze, bus.fwd_a, bus.fwd_b};
  endfunction

  task automatic drive(input vec_t t);
    bus.id_valid    = t.v;
    bus.id_rs1      = t.rs1;
    bus.id_rs2      = t.rs2;
    bus.id_use_rs1  = t.u1;
    bus.id_use_rs2  = t.u2;
    bus.id_rd       = t.rd;
    bus.id_regwrite = t.rw;
    bus.id_memread  = t.mr;
    bus.id_memwrite = t.mw;
    bus.ex_redirect = t.redir;
    bus.dmem_ready  = t.rdy;
  endtask

  task automatic check_outs(input string name, input logic [8:0] exp,
                            input logic dc);
    logic [8:0] mask;
    logic [8:0] act;
    mask = dc ? 9'h1F0 : 9'h1FF;
    act  = outs();
    n_vec++;
    if ((act & mask) !== (exp & mask)) begin
      n_err++;
      $display("FAIL %s: got {stall_if,stall_id,flush_id,flush_ex,freeze,fwd_a,fwd_b}=%b want %b (mask %b)",
               name, act, exp, mask);
    end
  endtask

  task automatic check_cnt(input string name, input logic [CNT_W-1:0] act,
                           input logic [CNT_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Drive one table row, score it at the falling edge, optionally clock it in
  task automatic apply(input int i, input bit advance);
    sb_t e;
    drive(tbl[i]);
    e.idx = i; e.exp = tbl[i].exp; e.dc = tbl[i].dc;
    sb_q.push_back(e);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard: empty queue at vector %0d", i);
    end else begin
      e = sb_q.pop_front();
      check_outs($sformatf("vec[%0d]", e.idx), e.exp, e.dc);
    end
    if (advance) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic vec_t nop(input logic redir, input logic rdy,
                               input logic st, input logic fid,
                               input logic fex, input logic frz,
                               input logic [1:0] fa, input logic [1:0] fb,
                               input logic dc);
    return mk(0,0,0,0,0,0,0,0,0, redir, rdy, st, fid, fex, frz, fa, fb, dc);
  endfunction

  logic [CNT_W-1:0] e_stall, e_flush, e_freeze;

  initial begin
    //            v rs1 rs2 u1 u2 rd rw mr mw rdr rdy | st fid fex frz fa fb dc
    // forward from MEM
    tbl.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0)); // 0 ADD x5
    tbl.push_back(mk(1, 5, 6, 1, 1, 8, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0)); // 1 SUB rs1=5
    tbl.push_back(nop(0, 1,                             0, 0, 0, 0, 1, 0, 0)); // 2 SUB in EX
    // MEM over WB
    tbl.push_back(mk(1, 0, 0, 1, 0, 7, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0)); // 3 x7 a
    tbl.push_back(mk(1, 0, 0, 1, 0, 7, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0)); // 4 x7 b
    tbl.push_back(mk(1, 0, 7, 0, 1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0)); // 5 read rs2=7
    tbl.push_back(nop(0, 1,                             0, 0, 0, 0, 0, 1, 0)); // 6 fwd_b=01
    // WB forward with a NOP in between
    tbl.push_back(mk(1, 0, 0, 1, 0, 7, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0)); // 7 x7 c
    tbl.push_back(nop(0, 1,                             0, 0, 0, 0, 0, 0, 0)); // 8
    tbl.push_back(mk(1, 0, 7, 0, 1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0)); // 9 read rs2=7
    tbl.push_back(nop(0, 1,                             0, 0, 0, 0, 0, 2, 0)); // 10 fwd_b=10
    // load-use
    tbl.push_back(mk(1, 0, 0, 1, 0, 3, 1, 1, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0)); // 11 LW x3
    tbl.push_back(mk(1, 3, 0, 1, 0, 4, 1, 0, 0, 0, 1,   1, 0, 1, 0, 0, 0, 0)); // 12 stall
    tbl.push_back(mk(1, 3, 0, 1, 0, 4, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 1)); // 13 ADD re-presented
    tbl.push_back(nop(0, 1,                             0, 0, 0, 0, 2, 0, 0)); // 14 fwd_a=10
    // register x0
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 1, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0)); // 15 LW x0
    tbl.push_back(mk(1, 0, 0, 1, 0, 4, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0)); // 16 no stall
    tbl.push_back(nop(0, 1,                             0, 0, 0, 0, 0, 0, 0)); // 17 fwd_a=00
    // redirect over load-use
    tbl.push_back(mk(1, 0, 0, 1, 0, 3, 1, 1, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0)); // 18 LW x3
    tbl.push_back(mk(1, 3, 0, 1, 0, 4, 1, 0, 0, 1, 1,   0, 1, 1, 0, 0, 0, 0)); // 19 redirect wins
    tbl.push_back(nop(1, 1,                             0, 0, 0, 0, 0, 0, 1)); // 20 EX invalid: no flush
    // freeze
    tbl.push_back(mk(1, 0, 0, 1, 0, 6, 1, 1, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0)); // 21 LW x6
    tbl.push_back(mk(1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0)); // 22 reads x6, no use bit
    tbl.push_back(nop(0, 0,                             1, 0, 0, 1, 1, 0, 0)); // 23 freeze 1
    tbl.push_back(nop(0, 0,                             1, 0, 0, 1, 1, 0, 0)); // 24 freeze 2
    tbl.push_back(nop(1, 0,                             1, 0, 0, 1, 1, 0, 0)); // 25 freeze 3, redirect held
    tbl.push_back(nop(1, 1,                             0, 1, 1, 0, 1, 0, 0)); // 26 redirect acted
    tbl.push_back(mk(1, 0, 0, 1, 0, 6, 1, 1, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0)); // 27 LW x6
    tbl.push_back(nop(0, 1,                             0, 0, 0, 0, 0, 0, 0)); // 28
    tbl.push_back(nop(0, 0,                             1, 0, 0, 1, 0, 0, 0)); // 29 freeze again

    // reset state
    reset = 1'b0;
    drive(nop(0, 1, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outs("reset_outs", 9'h000, 1'b0);
    check_cnt("reset_cnt_stall", bus.cnt_stall, '0);
    check_cnt("reset_cnt_freeze", bus.cnt_freeze, '0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 26; i++) apply(i, 1'b1);

`ifdef PERF_CNT_EN
    e_stall = 1; e_flush = 1; e_freeze = 3;
`else
    e_stall = 0; e_flush = 0; e_freeze = 0;
`endif
    check_cnt("cnt_stall", bus.cnt_stall, e_stall);
    check_cnt("cnt_flush", bus.cnt_flush, e_flush);
    check_cnt("cnt_freeze", bus.cnt_freeze, e_freeze);

    for (int i = 26; i < 29; i++) apply(i, 1'b1);
    apply(29, 1'b0);

    // asynchronous reset in the middle of a freeze
    #1;
    reset = 1'b0;
    #1;
    check_outs("midfreeze_reset_outs", 9'h000, 1'b0);
    check_cnt("midfreeze_reset_cnt_flush", bus.cnt_flush, '0);
    check_cnt("midfreeze_reset_cnt_freeze", bus.cnt_freeze, '0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    // dmem_ready still low, but the load was discarded
    check_outs("post_reset_no_freeze", 9'h000, 1'b0);

    if (sb_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard: %0d entries left, want 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
